// File: rtl/sweep_controller_pkg.sv
// Shared definitions for the sweep controller: FSM state encoding, sweep
// mode constants and the width of the downstream counter it drives.
package sweep_controller_pkg;

    localparam int CNT_W = 4;

    localparam logic MODE_SINGLE   = 1'b0;
    localparam logic MODE_PINGPONG = 1'b1;

    typedef enum logic [2:0] {
        SWEEP_IDLE,
        SWEEP_LOAD,
        SWEEP_UP,
        SWEEP_DOWN,
        SWEEP_DONE
    } sweep_state_t;

endpackage

// File: rtl/sweep_controller.sv
// Sweep sequencer placed in front of the 4-bit loadable up/down counter.
// On start it loads the counter with lo, counts up to hi and, in ping-pong
// mode, back down to lo for PASSES round trips. The counter value is read
// back on count_in to decide when each leg of the sweep ends.
module sweep_controller
    import sweep_controller_pkg::*;
#(
    parameter int PASSES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic             mode,
    input  logic [CNT_W-1:0] lo,
    input  logic [CNT_W-1:0] hi,
    input  logic [CNT_W-1:0] count_in,
    output logic             en,
    output logic             load,
    output logic             up_down_count,
    output logic [CNT_W-1:0] load_value,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int                PASS_W   = $clog2(PASSES + 1);
    localparam logic [PASS_W-1:0] PASSES_V = PASS_W'(PASSES);

    sweep_state_t      state_q, state_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0]  lo_q, lo_d;
    logic [CNT_W-1:0]  hi_q, hi_d;
    logic              mode_q, mode_d;
    logic              err_q, err_d;

    logic [CNT_W-1:0]  hi_m1;
    logic [CNT_W-1:0]  lo_p1;
    logic [PASS_W-1:0] pass_inc;

    // Next-state logic: abort wins, hold freezes everything, otherwise sequence the sweep.
    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        mode_d   = mode_q;
        err_d    = err_q;
        // lo_q < hi_q holds whenever these are used, so neither can wrap.
        hi_m1    = hi_q - 1'b1;
        lo_p1    = lo_q + 1'b1;
        pass_inc = pass_q + 1'b1;

        if (abort && (state_q != SWEEP_IDLE)) begin
            state_d = SWEEP_IDLE;
        end else if (!hold) begin
            case (state_q)
                SWEEP_IDLE: begin
                    if (start) begin
                        lo_d   = lo;
                        hi_d   = hi;
                        mode_d = mode;
                        pass_d = '0;
                        err_d  = (lo >= hi);
                        // An empty or inverted range completes at once, flagged as an error.
                        state_d = (lo >= hi) ? SWEEP_DONE : SWEEP_LOAD;
                    end
                end
                SWEEP_LOAD: begin
                    state_d = SWEEP_UP;
                end
                SWEEP_UP: begin
                    // The counter lands on hi_q on the same edge that leaves UP.
                    if (count_in == hi_m1) begin
                        state_d = (mode_q == MODE_PINGPONG) ? SWEEP_DOWN : SWEEP_DONE;
                    end
                end
                SWEEP_DOWN: begin
                    // The counter lands on lo_q on the edge that closes a round trip.
                    if (count_in == lo_p1) begin
                        pass_d  = pass_inc;
                        state_d = (pass_inc == PASSES_V) ? SWEEP_DONE : SWEEP_UP;
                    end
                end
                SWEEP_DONE: begin
                    state_d = SWEEP_IDLE;
                end
                default: begin
                    state_d = SWEEP_IDLE;
                end
            endcase
        end
    end

    // State and latched-request registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SWEEP_IDLE;
            pass_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            mode_q  <= MODE_SINGLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    // Counter control decoded from state; hold gates the enable so the counter freezes too.
    assign en            = ((state_q == SWEEP_LOAD) || (state_q == SWEEP_UP) ||
                            (state_q == SWEEP_DOWN)) && !hold;
    assign load          = (state_q == SWEEP_LOAD) && !hold;
    assign up_down_count = (state_q != SWEEP_DOWN);
    assign load_value    = lo_q;
    assign busy          = (state_q != SWEEP_IDLE);
    assign done          = (state_q == SWEEP_DONE);
    assign err           = (state_q == SWEEP_DONE) && err_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Bench for sweep_controller closed around a behavioural model of the 4-bit
// loadable up/down counter. Stimulus pushes the expected completion (cycle,
// err, counter value, whether the counter was enabled) into a queue; a
// monitor pops and compares each time the DUT pulses done.
module tb_sweep_controller;

    localparam int PASSES = 2;

    typedef struct {
        int         cyc;
        logic       err;
        logic [3:0] cnt;
        logic       en_any;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, hold, mode_i;
    logic [3:0] lo_i, hi_i;
    logic [3:0] cnt;
    logic       en, load, up_down_count, busy, done, err;
    logic [3:0] load_value;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q[$];
    logic en_seen = 1'b0;
    logic [3:0] last_count = 4'd0;

    sweep_controller #(.PASSES(PASSES)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .hold         (hold),
        .mode         (mode_i),
        .lo           (lo_i),
        .hi           (hi_i),
        .count_in     (cnt),
        .en           (en),
        .load         (load),
        .up_down_count(up_down_count),
        .load_value   (load_value),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream counter model.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 4'd0;
        else if (en) begin
            if (load) cnt <= load_value;
            else if (up_down_count) cnt <= cnt + 4'd1;
            else cnt <= cnt - 4'd1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare each done pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (!busy) en_seen = 1'b0;
            if (en) en_seen = 1'b1;
            if (done) begin
                if (q.size() == 0) begin
                    check("done_without_request", done, 0);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("err_at_done", err, e.err);
                    check("count_at_done", cnt, e.cnt);
                    check("en_activity", en_seen, e.en_any);
                end
            end
        end
    end

    // Issue one request and drive hold per cycle; called just after a posedge in IDLE.
    task automatic do_sweep(input logic [3:0] l, input logic [3:0] h, input logic m,
                            input int hold_at, input int hold_len, input bit rnd_hold);
        int   lat, nh, c0, k;
        bit   legal;
        exp_t e;
        legal  = (l < h);
        lo_i   = l;
        hi_i   = h;
        mode_i = m;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lo_i  = 4'($urandom);
        hi_i  = 4'($urandom);
        mode_i = 1'($urandom);
        c0 = cyc;
        if (!legal) lat = 1;
        else if (m) lat = 2 + 2 * (int'(h) - int'(l)) * PASSES;
        else lat = int'(h) - int'(l) + 2;
        check("busy_cycle1", busy, 1);
        check("load_cycle1", load, legal ? 1 : 0);
        nh = 0;
        k  = 1;
        while (k < lat + nh) begin
            if (hold_len > 0 && (k == hold_at || k == hold_at + hold_len))
                check("hold_frozen_count", cnt, int'(l) + hold_at - 2);
            hold = ((k >= hold_at) && (k < hold_at + hold_len)) ||
                   (rnd_hold && ($urandom_range(3) == 0));
            if (hold) nh++;
            @(posedge clk); #1;
            k++;
        end
        hold     = 1'b0;
        e.cyc    = c0 + lat + nh - 1;
        e.err    = !legal;
        e.cnt    = !legal ? last_count : (m ? l : h);
        e.en_any = legal;
        q.push_back(e);
        if (legal) last_count = m ? l : h;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   c0;
        rst = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
        mode_i = 1'b0; lo_i = 4'd0; hi_i = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_en", en, 0);
        check("rst_load", load, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_udc", up_down_count, 1);
        check("rst_load_value", load_value, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        do_sweep(4'd3, 4'd6, 1'b0, 0, 0, 1'b0);
        check("idle_en_after_single", en, 0);
        do_sweep(4'd2, 4'd4, 1'b1, 0, 0, 1'b0);
        do_sweep(4'd9, 4'd9, 1'b0, 0, 0, 1'b0);
        do_sweep(4'd12, 4'd5, 1'b1, 0, 0, 1'b0);
        do_sweep(4'd0, 4'd15, 1'b0, 5, 3, 1'b0);

        // Abort while counting down.
        lo_i = 4'd2; hi_i = 4'd4; mode_i = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("down_udc", up_down_count, 0);
        check("down_busy", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_en", en, 0);
        check("abort_count", cnt, 3);
        last_count = 4'd3;
        repeat (12) @(posedge clk);
        #1;

        // Asynchronous reset while counting up.
        lo_i = 4'd0; hi_i = 4'd15; mode_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_en", en, 0);
        check("arst_done", done, 0);
        check("arst_count", cnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        last_count = 4'd0;
        repeat (3) @(posedge clk);
        #1;

        // Narrow range with start re-asserted while busy and bounds changed.
        lo_i = 4'd14; hi_i = 4'd15; mode_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        lo_i = 4'd0; hi_i = 4'd9; mode_i = 1'b1;
        e.cyc = c0 + 2; e.err = 1'b0; e.cnt = 4'd15; e.en_any = 1'b1;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("busy_start_ignored", busy, 0);
        last_count = 4'd15;

        // Start held through DONE retriggers a second sweep.
        lo_i = 4'd5; hi_i = 4'd7; mode_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        e.cyc = c0 + 3;     e.err = 1'b0; e.cnt = 4'd7; e.en_any = 1'b1;
        q.push_back(e);
        e.cyc = c0 + 5 + 3; e.err = 1'b0; e.cnt = 4'd7; e.en_any = 1'b1;
        q.push_back(e);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        check("retrigger_load", load, 1);
        repeat (4) @(posedge clk);
        #1;
        last_count = 4'd7;

        // Randomized requests with random hold bursts.
        for (int i = 0; i < 24; i++) begin
            do_sweep(4'($urandom), 4'($urandom), 1'($urandom), 0, 0, 1'b1);
        end

        repeat (4) @(posedge clk);
        #1;
        check("pending_expectations", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
